hourglass_sort_arbiter: RTL and testbench
=========================================

Name: hourglass_sort_arbiter

Overview:
- Shares one hourglass_sorting_module between NUM_REQUESTERS clients, each presenting a full key vector.
- Grants jobs round-robin, registers the winner's keys, and pulses the sorter's load.
- Forwards the sorter's output stream tagged with the requester ID and a last flag.
- Accepts a new job only after the current job's last element has been transferred.

Parameters:
- NUM_REQUESTERS, 4, number of client request ports (>=2).
- REQ_ID_WIDTH, 2, width of requester tag; must be >= clog2(NUM_REQUESTERS).
- NUMBER_OF_ELEMENTS, 24, keys per job; must match the sorter.
- KEY_WIDTH, 8, bits per key.
- OUTPUT_INDEX_WIDTH, 5, width of the sorter's output index.
- TIMEOUT_CYCLES, 256, watchdog limit; used only with the optional feature.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-low reset (asserted when 0).
- req_valid  in  NUM_REQUESTERS  per-client job request.
- req_ready  out  NUM_REQUESTERS  one-hot accept pulse.
- req_keys  in  NUM_REQUESTERS*NUMBER_OF_ELEMENTS*KEY_WIDTH  client key vectors; client r occupies slice r.
- sorter_load  out  1  load pulse to the sorter.
- sorter_in_keys  out  NUMBER_OF_ELEMENTS*KEY_WIDTH  registered key vector of the granted job.
- sorter_out_key  in  KEY_WIDTH  sorter stream key.
- sorter_out_index  in  OUTPUT_INDEX_WIDTH  sorter stream index.
- sorter_out_valid  in  1  sorter stream valid.
- sorter_out_ready  out  1  sorter stream ready.
- axis_out_key  out  KEY_WIDTH  forwarded key.
- axis_out_index  out  OUTPUT_INDEX_WIDTH  forwarded index.
- axis_out_id  out  REQ_ID_WIDTH  owner of the current job.
- axis_out_last  out  1  high on the final element of a job.
- axis_out_valid  out  1  output valid.
- axis_out_ready  in  1  downstream ready.
- busy  out  1  high whenever state != IDLE.

Behaviour:
- Reset values: state=IDLE; req_ready=0; sorter_load=0; sorter_in_keys=0; owner=0; count=0; rr_ptr=0 (requester 0 has highest priority first); busy=0; axis_out_valid=0; sorter_out_ready=0.
- FSM states: IDLE, LOAD, DRAIN.
- IDLE:
  - Search req_valid starting at rr_ptr, wrapping modulo NUM_REQUESTERS; the first asserted bit wins.
  - On a win g: register req_keys slice g into sorter_in_keys, set owner=g, pulse req_ready[g] for exactly one cycle, set rr_ptr=(g+1) mod NUM_REQUESTERS, go to LOAD.
  - With no valid requester, stay in IDLE and leave rr_ptr unchanged.
- LOAD: sorter_load=1 for exactly one cycle, count cleared to 0, go to DRAIN.
- Latency: req_ready accept cycle -> sorter_load on the next cycle.
- DRAIN (combinational pass-through):
  - axis_out_valid = sorter_out_valid; sorter_out_ready = axis_out_ready.
  - key and index pass through; axis_out_id = owner.
  - axis_out_last = (count == NUMBER_OF_ELEMENTS-1).
  - count increments on each valid&ready transfer.
  - Transfer with axis_out_last=1 -> IDLE on the next cycle. This leaves one bubble cycle before the next grant.
- Outside DRAIN: axis_out_valid=0 and sorter_out_ready=0; sorter stream data is ignored.
- Counter width: clog2(NUMBER_OF_ELEMENTS); count never reaches NUMBER_OF_ELEMENTS.
- Client contract: req_valid must stay high until req_ready is seen. Dropping req_valid early is legal; no grant is issued for that client.
- req_ready is never asserted for more than one client in the same cycle, nor in LOAD or DRAIN.
- Simultaneous requests from all clients: grants occur in strict rotation from rr_ptr.
- Reset asserted mid-job (any state): immediate return to reset values; the partial job is discarded and no last is emitted. The sorter shares this reset.
- A new req_valid during DRAIN is held off until IDLE. Its keys are sampled only in the grant cycle.

Optional Feature:
- Macro: HOURGLASS_ARB_TIMEOUT_EN.
- When defined:
  - Adds output port timeout_err (1 bit, sticky, cleared only by reset).
  - A watchdog counter in DRAIN counts cycles with sorter_out_valid=0 and resets on every sorter_out_valid=1.
  - On reaching TIMEOUT_CYCLES: set timeout_err=1, abandon the job (no last emitted), return to IDLE.
- When undefined: no port and no counter; DRAIN waits indefinitely.

Test Plan:
- Single job: only req_valid[2]=1 with keys 3,1,0,2,... -> req_ready[2] pulses once; sorter_load fires 1 cycle later; 24 beats with axis_out_id=2, nondecreasing keys, axis_out_last only on beat 24; busy drops after the last beat.
- Fairness: req_valid=4'b1111 held for 4 jobs from reset -> grant order 0,1,2,3; then with only requesters 1 and 3 valid -> order 1,3,1.
- Backpressure: toggle axis_out_ready every other cycle during DRAIN -> sorter_out_ready mirrors it; exactly 24 transfers; no beat lost or duplicated; last on the 24th.
- Late request: req_valid[0] raised mid-DRAIN of job for requester 1 -> req_ready[0] is not asserted until 1 cycle after job 1's last transfer.
- Reset mid-DRAIN: assert rst=0 after beat 10 -> all outputs at reset values while low; after release, a new job on requester 3 completes normally with rr_ptr starting at 0.
- Timeout (macro defined, TIMEOUT_CYCLES=16): sorter stub never asserts valid after load -> timeout_err=1 after 16 DRAIN cycles; state returns to IDLE; next request is granted.

Source files
------------

// File: rtl/hourglass_sort_arbiter.sv
// hourglass_sort_arbiter
//   Shares a single hourglass_sorting_module between NUM_REQUESTERS clients.
//   A job is granted round-robin in IDLE. The winner's key vector is
//   registered into sorter_in_keys and the sorter is pulsed with sorter_load
//   in LOAD. In DRAIN the sorter's output stream is passed through to the
//   axis_out_* port, tagged with the owner ID and a last flag.
//
// Ports
//   clk, rst               clock (rising edge), async active-low reset
//   req_valid/req_ready    per-client request / one-hot accept pulse
//   req_keys               client key vectors, client r in slice r
//   sorter_load            one-cycle load pulse to the sorter
//   sorter_in_keys         registered key vector of the granted job
//   sorter_out_*           sorter output stream (key, index, valid/ready)
//   axis_out_*             forwarded stream (key, index, id, last, valid/ready)
//   busy                   high whenever the arbiter is not IDLE
//   timeout_err            sticky watchdog flag (HOURGLASS_ARB_TIMEOUT_EN only)
//
// Build option
//   HOURGLASS_ARB_TIMEOUT_EN : adds a DRAIN watchdog. If the sorter stays
//   silent for TIMEOUT_CYCLES consecutive cycles, the job is abandoned and
//   timeout_err is set.
module hourglass_sort_arbiter #(
  parameter int NUM_REQUESTERS     = 4,
  parameter int REQ_ID_WIDTH       = 2,
  parameter int NUMBER_OF_ELEMENTS = 24,
  parameter int KEY_WIDTH          = 8,
  parameter int OUTPUT_INDEX_WIDTH = 5,
  parameter int TIMEOUT_CYCLES     = 256
) (
  input  logic                                             clk,
  input  logic                                             rst,
  input  logic [NUM_REQUESTERS-1:0]                        req_valid,
  output logic [NUM_REQUESTERS-1:0]                        req_ready,
  input  logic [NUM_REQUESTERS*NUMBER_OF_ELEMENTS*KEY_WIDTH-1:0] req_keys,
  output logic                                             sorter_load,
  output logic [NUMBER_OF_ELEMENTS*KEY_WIDTH-1:0]          sorter_in_keys,
  input  logic [KEY_WIDTH-1:0]                             sorter_out_key,
  input  logic [OUTPUT_INDEX_WIDTH-1:0]                    sorter_out_index,
  input  logic                                             sorter_out_valid,
  output logic                                             sorter_out_ready,
  output logic [KEY_WIDTH-1:0]                             axis_out_key,
  output logic [OUTPUT_INDEX_WIDTH-1:0]                    axis_out_index,
  output logic [REQ_ID_WIDTH-1:0]                          axis_out_id,
  output logic                                             axis_out_last,
  output logic                                             axis_out_valid,
  input  logic                                             axis_out_ready,
  output logic                                             busy
`ifdef HOURGLASS_ARB_TIMEOUT_EN
  ,
  output logic                                             timeout_err
`endif
);

  localparam int KV_W  = NUMBER_OF_ELEMENTS * KEY_WIDTH;
  localparam int CNT_W = (NUMBER_OF_ELEMENTS > 1) ? $clog2(NUMBER_OF_ELEMENTS) : 1;
  // A misconfigured instance never grants rather than mis-tagging jobs.
  localparam bit CFG_OK = (NUM_REQUESTERS >= 2) &&
                          (REQ_ID_WIDTH >= $clog2(NUM_REQUESTERS)) &&
                          (TIMEOUT_CYCLES > 0);

  typedef enum logic [1:0] {IDLE, LOAD, DRAIN} state_t;

  state_t                  state, state_d;
  logic [REQ_ID_WIDTH-1:0] rr_ptr, owner, win_id, next_ptr;
  logic [CNT_W-1:0]        count;
  logic                    win, grant, xfer, is_last, wd_hit;
  int                      idx;

  // Rotating priority search: first asserted req_valid at or after rr_ptr.
  always_comb begin
    win    = 1'b0;
    win_id = '0;
    idx    = 0;
    for (int i = 0; i < NUM_REQUESTERS; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= NUM_REQUESTERS) idx = idx - NUM_REQUESTERS;
      if (!win && req_valid[idx]) begin
        win    = 1'b1;
        win_id = REQ_ID_WIDTH'(idx);
      end
    end
  end

  assign next_ptr = (int'(win_id) == NUM_REQUESTERS-1) ? '0 : win_id + 1'b1;
  assign is_last  = (count == CNT_W'(NUMBER_OF_ELEMENTS-1));

  // Stream data is a pure pass-through; only the handshake is gated by state.
  assign axis_out_key   = sorter_out_key;
  assign axis_out_index = sorter_out_index;
  assign axis_out_id    = owner;
  assign axis_out_last  = (state == DRAIN) && is_last;
  assign busy           = (state != IDLE);

  // Next-state and handshake outputs
  always_comb begin
    state_d          = state;
    req_ready        = '0;
    sorter_load      = 1'b0;
    axis_out_valid   = 1'b0;
    sorter_out_ready = 1'b0;
    grant            = 1'b0;
    xfer             = 1'b0;
    case (state)
      IDLE: begin
        // req_ready is combinational in the accept cycle; gating with rst
        // keeps it low while reset is held even if clients are requesting.
        if (win && rst && CFG_OK) begin
          grant     = 1'b1;
          req_ready = NUM_REQUESTERS'(1) << win_id;
          state_d   = LOAD;
        end
      end
      LOAD: begin
        sorter_load = 1'b1;
        state_d     = DRAIN;
      end
      DRAIN: begin
        axis_out_valid   = sorter_out_valid;
        sorter_out_ready = axis_out_ready;
        xfer             = sorter_out_valid && axis_out_ready;
        if (xfer && is_last) state_d = IDLE;
        if (wd_hit)          state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      sorter_in_keys <= '0;
      owner          <= '0;
      rr_ptr         <= '0;
      count          <= '0;
    end else begin
      state <= state_d;
      if (grant) begin
        sorter_in_keys <= req_keys[int'(win_id)*KV_W +: KV_W];
        owner          <= win_id;
        rr_ptr         <= next_ptr;
      end
      // Wrap to zero on the last beat so count never reaches the element count.
      if (state == LOAD)  count <= '0;
      else if (xfer)      count <= is_last ? '0 : count + 1'b1;
    end
  end

`ifdef HOURGLASS_ARB_TIMEOUT_EN
  localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [WD_W-1:0] wd;

  // Counts consecutive silent DRAIN cycles; fires on the TIMEOUT_CYCLES-th.
  assign wd_hit = (state == DRAIN) && !sorter_out_valid &&
                  (wd == WD_W'(TIMEOUT_CYCLES-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd          <= '0;
      timeout_err <= 1'b0;
    end else begin
      if (state != DRAIN || sorter_out_valid || wd_hit) wd <= '0;
      else                                              wd <= wd + 1'b1;
      if (wd_hit) timeout_err <= 1'b1;
    end
  end
`else
  assign wd_hit = 1'b0;
`endif

endmodule

// File: tb/tb_hourglass_sort_arbiter.sv
// Bench for hourglass_sort_arbiter. A behavioural sorter stub streams the
// sorted registered keys. Expected grants and beats are queued when the
// stimulus is issued, and a negedge monitor pops and compares them.
// Client r uses keys 40*r + (5*e mod 24), so its sorted stream is 40*r + j.
module tb_hourglass_sort_arbiter;
  localparam int N  = 4;
  localparam int E  = 24;
  localparam int KW = 8;
  localparam int IW = 5;
  localparam int DW = 2;
`ifdef HOURGLASS_ARB_TIMEOUT_EN
  localparam int TO = 16;
`else
  localparam int TO = 256;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_valid, req_ready;
  logic [N*E*KW-1:0] req_keys;
  logic              sorter_load;
  logic [E*KW-1:0]   sorter_in_keys;
  logic [KW-1:0]     sorter_out_key;
  logic [IW-1:0]     sorter_out_index;
  logic              sorter_out_valid, sorter_out_ready;
  logic [KW-1:0]     axis_out_key;
  logic [IW-1:0]     axis_out_index;
  logic [DW-1:0]     axis_out_id;
  logic              axis_out_last, axis_out_valid, axis_out_ready;
  logic              busy;
`ifdef HOURGLASS_ARB_TIMEOUT_EN
  logic              timeout_err;
`endif

  hourglass_sort_arbiter #(
    .NUM_REQUESTERS(N), .REQ_ID_WIDTH(DW), .NUMBER_OF_ELEMENTS(E),
    .KEY_WIDTH(KW), .OUTPUT_INDEX_WIDTH(IW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_keys(req_keys),
    .sorter_load(sorter_load), .sorter_in_keys(sorter_in_keys),
    .sorter_out_key(sorter_out_key), .sorter_out_index(sorter_out_index),
    .sorter_out_valid(sorter_out_valid), .sorter_out_ready(sorter_out_ready),
    .axis_out_key(axis_out_key), .axis_out_index(axis_out_index),
    .axis_out_id(axis_out_id), .axis_out_last(axis_out_last),
    .axis_out_valid(axis_out_valid), .axis_out_ready(axis_out_ready),
    .busy(busy)
`ifdef HOURGLASS_ARB_TIMEOUT_EN
    , .timeout_err(timeout_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [KW-1:0] key;
    logic [IW-1:0] idx;
    logic [DW-1:0] id;
    logic          last;
  } beat_t;

  beat_t exp_q[$];
  int    grant_q[$];
  int    checks = 0, errors = 0;
  int    raise_cnt[N], served_cnt[N];
  logic  bp_mode = 1'b0, mute = 1'b0;
  // monitor-owned
  int    cyc = 0, beats_seen = 0, last_cyc = 0, grant_gap = 0;
  logic  prev_grant = 1'b0, after_last = 1'b0;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endfunction

  task automatic push_job(input int r);
    grant_q.push_back(r);
    for (int j = 0; j < E; j++)
      exp_q.push_back('{key: KW'(40*r + j), idx: IW'(j), id: DW'(r), last: (j == E-1)});
  endtask

  always_comb begin
    req_valid = '0;
    for (int r = 0; r < N; r++) req_valid[r] = (raise_cnt[r] != served_cnt[r]);
  end

  // Client side: drop a request once its accept pulse is seen.
  initial begin
    logic [N-1:0] rr;
    logic         ok;
    for (int r = 0; r < N; r++) served_cnt[r] = 0;
    forever begin
      @(negedge clk);
      rr = req_ready;
      ok = rst;
      @(posedge clk); #1;
      if (ok) for (int r = 0; r < N; r++) if (rr[r]) served_cnt[r]++;
    end
  end

  // Downstream ready: steady high, or toggling each cycle under backpressure.
  initial begin
    axis_out_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      axis_out_ready = bp_mode ? ~axis_out_ready : 1'b1;
    end
  end

  // Sorter stub: captures keys on load, streams them in ascending order.
  initial begin
    logic [KW-1:0]   sk[E];
    logic [KW-1:0]   t;
    logic [E*KW-1:0] cap;
    logic            fire, ld, streaming;
    int              k;
    streaming = 1'b0; k = 0;
    for (int e = 0; e < E; e++) sk[e] = '0;
    sorter_out_valid = 1'b0; sorter_out_key = '0; sorter_out_index = '0;
    forever begin
      @(negedge clk);
      fire = sorter_out_valid && sorter_out_ready;
      ld   = sorter_load;
      cap  = sorter_in_keys;
      @(posedge clk); #1;
      if (!rst) begin
        streaming = 1'b0; k = 0;
      end else if (ld) begin
        for (int e = 0; e < E; e++) sk[e] = cap[e*KW +: KW];
        for (int a = 0; a < E-1; a++)
          for (int b = 0; b < E-1-a; b++)
            if (sk[b] > sk[b+1]) begin t = sk[b]; sk[b] = sk[b+1]; sk[b+1] = t; end
        k = 0; streaming = 1'b1;
      end else if (fire) begin
        if (k == E-1) streaming = 1'b0; else k++;
      end
      sorter_out_valid = streaming && !mute;
      sorter_out_key   = sk[k];
      sorter_out_index = IW'(k);
    end
  end

  // Monitor / scoreboard
  initial begin
    beat_t ex;
    int    g;
    forever begin
      @(negedge clk);
      cyc++;
      if (!rst) begin
        prev_grant = 1'b0; after_last = 1'b0;
      end else begin
        if (req_ready != '0) begin
          chk("ready_onehot", $countones(req_ready), 1);
          chk("ready_only_idle", busy, 0);
          grant_gap = cyc - last_cyc;
          if (grant_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_grant actual=%0h required=none", req_ready);
          end else begin
            g = grant_q.pop_front();
            chk("grant_id", req_ready, 64'(1) << g);
          end
        end
        if (sorter_load) chk("load_latency", prev_grant, 1);
        prev_grant = |req_ready;
        if (after_last) chk("busy_after_last", busy, 0);
        after_last = 1'b0;
        if (busy && !sorter_load) begin
          chk("ready_mirror", sorter_out_ready, axis_out_ready);
          chk("valid_mirror", axis_out_valid, sorter_out_valid);
        end else begin
          chk("quiet_outside_drain", {axis_out_valid, sorter_out_ready}, 0);
        end
        if (axis_out_valid && axis_out_ready) begin
          beats_seen++;
          if (exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_beat actual=%0h required=none", axis_out_key);
          end else begin
            ex = exp_q.pop_front();
            chk("beat_key",  axis_out_key,   ex.key);
            chk("beat_idx",  axis_out_index, ex.idx);
            chk("beat_id",   axis_out_id,    ex.id);
            chk("beat_last", axis_out_last,  ex.last);
          end
          if (axis_out_last) begin after_last = 1'b1; last_cyc = cyc; end
        end
      end
    end
  end

  task automatic wait_drain(input string name, input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && grant_q.size() == 0 && !busy) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout actual=pending(%0d beats,%0d grants) required=drained",
               name, exp_q.size(), grant_q.size());
    end
  endtask

  task automatic wait_beats(input string name, input int target, input int limit);
    bit done = 0;
    for (int i = 0; i < limit && !done; i++) begin
      @(negedge clk);
      if (beats_seen >= target) done = 1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s_timeout actual=%0d required=%0d", name, beats_seen, target);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_load"},      sorter_load, 0);
    chk({tag, "_keys_zero"}, (sorter_in_keys == '0), 1);
    chk({tag, "_busy"},      busy, 0);
    chk({tag, "_valid"},     axis_out_valid, 0);
    chk({tag, "_sready"},    sorter_out_ready, 0);
    chk({tag, "_id"},        axis_out_id, 0);
  endtask

  initial begin
    int b0, n;
    bit seen;
    for (int r = 0; r < N; r++) raise_cnt[r] = 0;
    for (int r = 0; r < N; r++)
      for (int e = 0; e < E; e++)
        req_keys[(r*E + e)*KW +: KW] = KW'(40*r + (e*5) % 24);

    // Reset with every client already requesting
    rst = 1'b0;
    for (int r = 0; r < N; r++) raise_cnt[r]++;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
`ifdef HOURGLASS_ARB_TIMEOUT_EN
    chk("reset_timeout_err", timeout_err, 0);
`endif

    // Fairness from reset: 0,1,2,3
    for (int r = 0; r < N; r++) push_job(r);
    rst = 1'b1;
    wait_drain("fair_all", 1000);

    // Only 1 and 3 (1 twice): 1,3,1
    push_job(1); push_job(3); push_job(1);
    @(posedge clk); #1;
    raise_cnt[1] += 2; raise_cnt[3]++;
    wait_drain("fair_1_3", 1000);

    // Single job on requester 2
    push_job(2);
    @(posedge clk); #1;
    raise_cnt[2]++;
    wait_drain("single_2", 500);

    // Backpressure on requester 3
    push_job(3);
    @(posedge clk); #1;
    bp_mode = 1'b1;
    raise_cnt[3]++;
    wait_drain("backpressure", 500);
    bp_mode = 1'b0;

    // Late request from 0 during requester 1's drain
    push_job(1);
    @(posedge clk); #1;
    raise_cnt[1]++;
    b0 = beats_seen;
    wait_beats("late_mid", b0 + 5, 300);
    push_job(0);
    @(posedge clk); #1;
    raise_cnt[0]++;
    wait_drain("late", 500);
    chk("late_grant_gap", grant_gap, 1);

    // Reset after beat 10 of a job on requester 1 (rr_ptr would be 2)
    push_job(1);
    @(posedge clk); #1;
    raise_cnt[1]++;
    b0 = beats_seen;
    wait_beats("rst_mid", b0 + 10, 300);
    @(posedge clk); #1;
    rst = 1'b0;
    exp_q.delete();
    raise_cnt[1]++; raise_cnt[3]++;
    #1;
    check_reset_outputs("midrst");
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("midrst_hold");
    // rr_ptr back at 0: 1 wins before 3
    push_job(1); push_job(3);
    rst = 1'b1;
    wait_drain("after_rst", 1000);

`ifdef HOURGLASS_ARB_TIMEOUT_EN
    // Silent sorter: watchdog abandons the job after TO DRAIN cycles
    mute = 1'b1;
    grant_q.push_back(2);
    @(posedge clk); #1;
    raise_cnt[2]++;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (busy) seen = 1;
    end
    chk("to_granted", seen, 1);
    n = 0;
    for (int i = 0; i < 200 && busy; i++) begin
      if (!sorter_load) n++;
      @(negedge clk);
    end
    chk("to_drain_cycles", n, TO);
    chk("to_err_set", timeout_err, 1);
    chk("to_idle", busy, 0);
    mute = 1'b0;
    push_job(0);
    @(posedge clk); #1;
    raise_cnt[0]++;
    wait_drain("after_to", 500);
    chk("to_err_sticky", timeout_err, 1);
`else
    seen = 0; n = 0;
    chk("idle_end", busy | seen | (n != 0), 0);
`endif

    chk("exp_q_empty", exp_q.size(), 0);
    chk("grant_q_empty", grant_q.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
